alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single integer ALU between NREQ requesters, e.g. the execute stage and an address-generation or debug unit.
- Each requester issues one operation (srcA, srcB, ALUControl) through a valid/ready handshake.
- The arbiter grants one requester at a time, drives the ALU, and registers the 32-bit result and 4-bit flags {N,Z,C,V}.
- It holds the response to the granted requester until that requester accepts it.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GW, $clog2(NREQ) (min 1), width of the grant index.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester operation accepted this cycle.
- req_srcA  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- req_srcB  in  32*NREQ  operand B, packed as req_srcA.
- req_ctrl  in  4*NREQ  ALUControl code; requester i uses bits [4i+3:4i].
- resp_valid  out  NREQ  per-requester result valid (one-hot or zero).
- resp_ready  in  NREQ  per-requester result accept.
- resp_result  out  32  registered ALUResult, shared by all requesters.
- resp_flags  out  4  registered flags {N,Z,C,V}.
- alu_srcA  out  32  to ALU srcA.
- alu_srcB  out  32  to ALU srcB.
- alu_ctrl  out  4  to ALU ALUControl.
- alu_result  in  32  from ALU ALUResult (combinational).
- alu_flags  in  4  from ALU flags (combinational).
- busy  out  1  high while in RESP.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, resp_valid=0, resp_result=0, resp_flags=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - rst overrides everything, including a handshake in the same cycle. An in-flight response is discarded and never re-presented.
- State IDLE:
  - grant g = first i with req_valid[i]=1, searching cyclically from (last+1) mod NREQ.
  - req_ready is one-hot at g when any req_valid is high, otherwise all zero. req_ready never depends on resp_ready.
  - alu_srcA/alu_srcB/alu_ctrl are driven combinationally from requester g's slice.
  - With no request, these ALU outputs are 0/0/4'b0000.
  - On a cycle with req_valid[g]&req_ready[g]:
    - capture alu_result into resp_result and alu_flags into resp_flags;
    - set resp_valid[g]=1, last=g, state=RESP.
- State RESP:
  - req_ready=0; busy=1.
  - ALU inputs are held at the captured requester's current slice; they are don't-care for results.
  - resp_result/resp_flags stay stable until acceptance.
  - On resp_ready[g]=1: resp_valid cleared next edge, state=IDLE.
  - resp_ready bits of other requesters are ignored.
- Latency and throughput:
  - Result is visible 1 cycle after the request handshake.
  - Minimum 2 cycles per operation: handshake cycle, then response accept cycle.
- A requester must hold req_valid and its operands stable until req_ready. Deasserting before then withdraws the request without error.
- ALUControl codes are passed unchanged, undefined codes included; the ALU returns 0 for those.
- Simultaneous requests are resolved only by the round-robin order. No requester waits more than NREQ-1 grants.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index valid requester always wins and `last` is not used. This gives the execute stage (index 0) guaranteed immediate access.
  - Not defined: round-robin as described above.

Test Plan:
- Reset, then requester 0 sends srcA=5, srcB=3, ctrl=0000 (ADD) -> req_ready[0]=1 that cycle. Next cycle resp_valid=2'b01, resp_result=8, resp_flags=4'b0000.
- Requester 1 sends SUB (0001) with 3,3 -> resp_result=0, resp_flags=4'b0110 (Z=1, C=1), resp_valid=2'b10.
- Both requesters hold valid continuously with resp_ready tied high -> grant order 0,1,0,1,0,1; one result every 2 cycles; each resp_result matches its own operands.
- Hold resp_ready low 5 cycles after a grant -> resp_result/resp_flags/resp_valid stable, req_ready=0, busy=1 throughout. Release -> IDLE next cycle.
- Assert rst while in RESP with resp_valid=2'b01 -> next edge resp_valid=0, resp_result=0, state IDLE. First grant after reset goes to requester 0 when both request.
- With ALU_ARB_FIXED_PRIO_EN defined and both requesters valid continuously -> requester 0 granted every time, requester 1 never granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request/response bundle between NREQ requesters and the ALU
//               arbiter. Each requester owns one 32-bit srcA/srcB slice and
//               one 4-bit ALUControl slice. All requesters share one result
//               and one flags bus, qualified per requester by resp_valid.
// Ports       : req_valid/req_ready     - per-requester operation handshake
//               req_srcA/req_srcB       - packed operands, 32 bits each
//               req_ctrl                - packed ALUControl, 4 bits each
//               resp_valid/resp_ready   - per-requester result handshake
//               resp_result/resp_flags  - shared registered result {N,Z,C,V}
//               modport master = requester side, slave = arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_srcA;
    logic [32*NREQ-1:0] req_srcB;
    logic [4*NREQ-1:0]  req_ctrl;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [31:0]        resp_result;
    logic [3:0]         resp_flags;

    modport master (
        output req_valid,
        output req_srcA,
        output req_srcB,
        output req_ctrl,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_result,
        input  resp_flags
    );

    modport slave (
        input  req_valid,
        input  req_srcA,
        input  req_srcB,
        input  req_ctrl,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_result,
        output resp_flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational integer ALU between NREQ requesters.
//               One requester is granted at a time, its operands are steered
//               to the ALU, and the ALU result and flags {N,Z,C,V} are
//               registered and held until that requester accepts them.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               bus (slave)       - request/response bundle (alu_arbiter_if)
//               alu_srcA/srcB/ctrl- operands/ALUControl to the ALU
//               alu_result/flags  - combinational ALU outputs
//               busy              - high while a response is outstanding
// Config      : `define ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest
//               index wins); otherwise round-robin starting after the last
//               granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int GW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_arbiter_if.slave     bus,
    output logic [31:0]      alu_srcA,
    output logic [31:0]      alu_srcB,
    output logic [3:0]       alu_ctrl,
    input  wire logic [31:0] alu_result,
    input  wire logic [3:0]  alu_flags,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [NREQ-1:0] ONEHOT_ZERO = {{(NREQ-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          state_q,       state_d;
    logic [NREQ-1:0] resp_valid_q,  resp_valid_d;
    logic [31:0]     resp_result_q, resp_result_d;
    logic [3:0]      resp_flags_q,  resp_flags_d;
    logic [GW-1:0]   owner_q,       owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [GW-1:0]   last_q,        last_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [31:0]     w_srcA_arr [NREQ];
    logic [31:0]     w_srcB_arr [NREQ];
    logic [3:0]      w_ctrl_arr [NREQ];
    logic            w_grant_found;
    logic [GW-1:0]   w_grant_idx;
    logic [NREQ-1:0] w_grant_onehot;
    logic [GW-1:0]   w_sel_idx;
    logic            w_alu_drive;
    logic [NREQ-1:0] w_req_ready;

    // Unpack the per-requester slices so they can be selected by index.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_srcA_arr[gi] = bus.req_srcA[32*gi +: 32];
            assign w_srcB_arr[gi] = bus.req_srcB[32*gi +: 32];
            assign w_ctrl_arr[gi] = bus.req_ctrl[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration: cyclic search for the first valid requester, starting just
    // after the last winner (round-robin) or at index 0 (fixed priority).
    // ------------------------------------------------------------------------
    always_comb begin : p_arb
        int start;
        int idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        idx           = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (int'(last_q) + 1) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = (start + k) % NREQ;
            if (!w_grant_found && bus.req_valid[GW'(idx)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = GW'(idx);
            end
        end
    end

    assign w_grant_onehot = ONEHOT_ZERO << w_grant_idx;

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin : p_fsm
        state_d       = state_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        owner_d       = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        w_req_ready   = '0;
        w_sel_idx     = owner_q;
        w_alu_drive   = 1'b0;
        busy          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_sel_idx = w_grant_idx;
                // A found grant implies req_valid[g], so ready=1 here is a
                // completed handshake: capture the ALU output right away.
                if (w_grant_found) begin
                    w_alu_drive   = 1'b1;
                    w_req_ready   = w_grant_onehot;
                    resp_result_d = alu_result;
                    resp_flags_d  = alu_flags;
                    resp_valid_d  = w_grant_onehot;
                    owner_d       = w_grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d        = w_grant_idx;
`endif
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                busy        = 1'b1;
                // Keep the ALU pointed at the owner; its output is ignored.
                w_alu_drive = 1'b1;
                // Only the owner's resp_ready can retire the response.
                if (bus.resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu_srcA = w_alu_drive ? w_srcA_arr[w_sel_idx] : 32'd0;
    assign alu_srcB = w_alu_drive ? w_srcB_arr[w_sel_idx] : 32'd0;
    assign alu_ctrl = w_alu_drive ? w_ctrl_arr[w_sel_idx] : 4'b0000;

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags  = resp_flags_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            owner_q       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            // Pointing at the top index makes requester 0 first in line.
            last_q        <= GW'(NREQ - 1);
`endif
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            owner_q       <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q        <= last_d;
`endif
        end
    end

endmodule
`default_nettype wire
